// File: rtl/register_file_sb_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Register 0 is hardwired to zero and never tracked as busy.
    function automatic logic is_zero_addr(input int unsigned addr);
        return addr == 0;
    endfunction

endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus of the register file; the master side is decode plus ALU.
interface register_file_sb_if import regfile_pkg::*; #(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG)
);
    logic            read_en;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            rd_we;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic            operand_ready;
    logic            stall;
    logic            req_drop;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic [NREG-1:0] busy_vec;
    logic [XLEN-1:0] dbg_data;

    modport master (
        output read_en, rs1, rs2, rd, rd_we, wb_valid, wb_addr, wb_data,
        input  r1, r2, operand_ready, stall, req_drop, busy_vec, dbg_data
    );

    modport slave (
        input  read_en, rs1, rs2, rd, rd_we, wb_valid, wb_addr, wb_data,
        output r1, r2, operand_ready, stall, req_drop, busy_vec, dbg_data
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Per-register busy bits with set-wins update and a combinational hazard query.
module reg_scoreboard import regfile_pkg::*; #(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en_i,
    input  logic [AW-1:0]   set_addr_i,
    input  logic            clr_en_i,
    input  logic [AW-1:0]   clr_addr_i,
    input  logic [AW-1:0]   q_rs1_i,
    input  logic [AW-1:0]   q_rs2_i,
    input  logic [AW-1:0]   q_rd_i,
    input  logic            q_rd_en_i,
    input  logic            byp_en_i,
    input  logic [AW-1:0]   byp_addr_i,
    output logic            hazard_c_o,
    output logic [NREG-1:0] busy_o
);
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // A busy bit blocks unless it is register 0 or is being cleared by a bypassed writeback.
    function automatic logic blocked(input logic [NREG-1:0] busy, input logic [AW-1:0] a,
                                     input logic byp_en, input logic [AW-1:0] byp_addr);
        return busy[a] && !is_zero_addr(32'(a)) && !(byp_en && (a == byp_addr));
    endfunction

    // Clear first, then set, so a same-edge issue keeps the new write outstanding.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (set_en_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Hazard on either source, or on the destination when it will be written.
    always_comb begin
        hazard_c_o = blocked(busy_q, q_rs1_i, byp_en_i, byp_addr_i)
                   | blocked(busy_q, q_rs2_i, byp_en_i, byp_addr_i)
                   | (q_rd_en_i & blocked(busy_q, q_rd_i, byp_en_i, byp_addr_i));
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/register_file_sb.sv
// Register file with busy scoreboard, optional writeback bypass and a debug tap.
module register_file_sb import regfile_pkg::*; #(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned NREG    = NREG_DEF,
    parameter int unsigned AW      = $clog2(NREG),
    parameter int unsigned DBG_REG = 31,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    register_file_sb_if.slave bus
);
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] dbg_q;

    state_e          state_q;
    logic [AW-1:0]   cap_rs1_q;
    logic [AW-1:0]   cap_rs2_q;
    logic [AW-1:0]   cap_rd_q;
    logic            cap_we_q;
    logic [XLEN-1:0] r1_q;
    logic [XLEN-1:0] r2_q;
    logic            ready_q;
    logic            stall_q;
    logic            drop_q;

    logic [AW-1:0]   sel_rs1;
    logic [AW-1:0]   sel_rs2;
    logic [AW-1:0]   sel_rd;
    logic            sel_we;
    logic            req_live;
    logic            wb_hit;
    logic            byp_en;
    logic            hazard;
    logic            issue;
    logic            set_en;
    logic [XLEN-1:0] opnd1_d;
    logic [XLEN-1:0] opnd2_d;
    logic [NREG-1:0] busy;

    // In IDLE the live request is evaluated; in WAIT the captured one.
    always_comb begin
        sel_rs1  = bus.rs1;
        sel_rs2  = bus.rs2;
        sel_rd   = bus.rd;
        sel_we   = bus.rd_we;
        req_live = bus.read_en;
        if (state_q == WAIT) begin
            sel_rs1  = cap_rs1_q;
            sel_rs2  = cap_rs2_q;
            sel_rd   = cap_rd_q;
            sel_we   = cap_we_q;
            req_live = 1'b1;
        end
    end

    assign wb_hit = bus.wb_valid && !is_zero_addr(32'(bus.wb_addr));
    assign byp_en = BYPASS && wb_hit;
    assign issue  = req_live && !hazard;
    assign set_en = issue && sel_we && !is_zero_addr(32'(sel_rd));

    // Operand read; register 0 is never written so it always reads zero.
    always_comb begin
        opnd1_d = regs_q[sel_rs1];
        opnd2_d = regs_q[sel_rs2];
        if (byp_en && (bus.wb_addr == sel_rs1)) opnd1_d = bus.wb_data;
        if (byp_en && (bus.wb_addr == sel_rs2)) opnd2_d = bus.wb_data;
    end

    reg_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (set_en),
        .set_addr_i (sel_rd),
        .clr_en_i   (wb_hit),
        .clr_addr_i (bus.wb_addr),
        .q_rs1_i    (sel_rs1),
        .q_rs2_i    (sel_rs2),
        .q_rd_i     (sel_rd),
        .q_rd_en_i  (sel_we),
        .byp_en_i   (byp_en),
        .byp_addr_i (bus.wb_addr),
        .hazard_c_o (hazard),
        .busy_o     (busy)
    );

    // Writeback into the array and the debug tap on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
            dbg_q  <= '0;
        end else if (wb_hit) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
            if (bus.wb_addr == AW'(DBG_REG)) dbg_q <= bus.wb_data;
        end
    end

    // Request FSM: capture, stall on hazard, deliver operands with a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cap_rs1_q <= '0;
            cap_rs2_q <= '0;
            cap_rd_q  <= '0;
            cap_we_q  <= 1'b0;
            r1_q      <= '0;
            r2_q      <= '0;
            ready_q   <= 1'b0;
            stall_q   <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            drop_q  <= (state_q == WAIT) && bus.read_en;
            if ((state_q == IDLE) && bus.read_en) begin
                cap_rs1_q <= bus.rs1;
                cap_rs2_q <= bus.rs2;
                cap_rd_q  <= bus.rd;
                cap_we_q  <= bus.rd_we;
            end
            if (issue) begin
                r1_q    <= opnd1_d;
                r2_q    <= opnd2_d;
                ready_q <= 1'b1;
                stall_q <= 1'b0;
                state_q <= IDLE;
            end else if (req_live) begin
                stall_q <= 1'b1;
                state_q <= WAIT;
            end
        end
    end

    assign bus.r1            = r1_q;
    assign bus.r2            = r2_q;
    assign bus.operand_ready = ready_q;
    assign bus.stall         = stall_q;
    assign bus.req_drop      = drop_q;
    assign bus.busy_vec      = busy;
    assign bus.dbg_data      = dbg_q;

endmodule

// File: tb/tb_register_file_sb.sv
// Bench: one bypassing and one non-bypassing register file driven with the same stimulus.
module tb_register_file_sb;
    import regfile_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            read_en;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            rd_we;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) bus_b1 ();
    register_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) bus_b0 ();

    assign bus_b1.read_en  = read_en;
    assign bus_b1.rs1      = rs1;
    assign bus_b1.rs2      = rs2;
    assign bus_b1.rd       = rd;
    assign bus_b1.rd_we    = rd_we;
    assign bus_b1.wb_valid = wb_valid;
    assign bus_b1.wb_addr  = wb_addr;
    assign bus_b1.wb_data  = wb_data;
    assign bus_b0.read_en  = read_en;
    assign bus_b0.rs1      = rs1;
    assign bus_b0.rs2      = rs2;
    assign bus_b0.rd       = rd;
    assign bus_b0.rd_we    = rd_we;
    assign bus_b0.wb_valid = wb_valid;
    assign bus_b0.wb_addr  = wb_addr;
    assign bus_b0.wb_data  = wb_data;

    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .DBG_REG(31), .BYPASS(1'b1)) dut_b1 (
        .clk (clk),
        .rst (rst),
        .bus (bus_b1)
    );

    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .DBG_REG(31), .BYPASS(1'b0)) dut_b0 (
        .clk (clk),
        .rst (rst),
        .bus (bus_b0)
    );

    // Reference model, index 1 = bypass enabled, index 0 = bypass disabled.
    logic [XLEN-1:0] m_regs [2][NREG];
    bit              m_busy [2][NREG];
    bit              m_pend [2];
    int              m_rs1 [2];
    int              m_rs2 [2];
    int              m_rd  [2];
    bit              m_we  [2];
    logic [XLEN-1:0] e_r1 [2];
    logic [XLEN-1:0] e_r2 [2];
    bit              e_rdy [2];
    bit              e_drop [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < int'(NREG); i++) begin
                m_regs[k][i] = '0;
                m_busy[k][i] = 1'b0;
            end
            m_pend[k] = 1'b0;
            e_r1[k]   = '0;
            e_r2[k]   = '0;
            e_rdy[k]  = 1'b0;
            e_drop[k] = 1'b0;
        end
    endtask

    function automatic bit stuck(input int k, input int a, input bit byp, input int wa);
        return (a != 0) && m_busy[k][a] && !(byp && (a == wa));
    endfunction

    function automatic logic [XLEN-1:0] fetch(input int k, input int a, input bit byp, input int wa);
        if (a == 0) return '0;
        if (byp && (a == wa)) return wb_data;
        return m_regs[k][a];
    endfunction

    function automatic logic [NREG-1:0] exp_busy(input int k);
        logic [NREG-1:0] v;
        for (int i = 0; i < int'(NREG); i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    // Advance model k by one clock using the inputs currently driven.
    task automatic model_step(input int k);
        int a1;
        int a2;
        int ad;
        int wa;
        bit we;
        bit have;
        bit hz;
        bit setrd;
        bit wclr;
        bit byp;
        wa   = int'(wb_addr);
        wclr = wb_valid && (wa != 0);
        byp  = (k == 1) && wclr;
        e_drop[k] = m_pend[k] && read_en;
        if (m_pend[k]) begin
            a1 = m_rs1[k]; a2 = m_rs2[k]; ad = m_rd[k]; we = m_we[k];
        end else begin
            a1 = int'(rs1); a2 = int'(rs2); ad = int'(rd); we = rd_we;
        end
        have  = m_pend[k] || read_en;
        hz    = stuck(k, a1, byp, wa) || stuck(k, a2, byp, wa) || (we && stuck(k, ad, byp, wa));
        e_rdy[k] = 1'b0;
        setrd = 1'b0;
        if (have && !hz) begin
            e_r1[k]   = fetch(k, a1, byp, wa);
            e_r2[k]   = fetch(k, a2, byp, wa);
            e_rdy[k]  = 1'b1;
            m_pend[k] = 1'b0;
            setrd     = we && (ad != 0);
        end else if (have) begin
            m_pend[k] = 1'b1;
            m_rs1[k] = a1; m_rs2[k] = a2; m_rd[k] = ad; m_we[k] = we;
        end
        if (wclr) begin
            m_regs[k][wa] = wb_data;
            m_busy[k][wa] = 1'b0;
        end
        if (setrd) m_busy[k][ad] = 1'b1;
    endtask

    task automatic compare_all();
        check("b1.r1",    64'(bus_b1.r1),            64'(e_r1[1]));
        check("b1.r2",    64'(bus_b1.r2),            64'(e_r2[1]));
        check("b1.ready", 64'(bus_b1.operand_ready), 64'(e_rdy[1]));
        check("b1.stall", 64'(bus_b1.stall),         64'(m_pend[1]));
        check("b1.drop",  64'(bus_b1.req_drop),      64'(e_drop[1]));
        check("b1.busy",  64'(bus_b1.busy_vec),      64'(exp_busy(1)));
        check("b1.dbg",   64'(bus_b1.dbg_data),      64'(m_regs[1][31]));
        check("b0.r1",    64'(bus_b0.r1),            64'(e_r1[0]));
        check("b0.r2",    64'(bus_b0.r2),            64'(e_r2[0]));
        check("b0.ready", 64'(bus_b0.operand_ready), 64'(e_rdy[0]));
        check("b0.stall", 64'(bus_b0.stall),         64'(m_pend[0]));
        check("b0.drop",  64'(bus_b0.req_drop),      64'(e_drop[0]));
        check("b0.busy",  64'(bus_b0.busy_vec),      64'(exp_busy(0)));
        check("b0.dbg",   64'(bus_b0.dbg_data),      64'(m_regs[0][31]));
    endtask

    // One clock of stimulus, model update and comparison.
    task automatic cyc(input bit re, input int a1, input int a2, input int ad, input bit we,
                       input bit wv, input int wa, input logic [XLEN-1:0] wd);
        read_en  = re;
        rs1      = AW'(a1);
        rs2      = AW'(a2);
        rd       = AW'(ad);
        rd_we    = we;
        wb_valid = wv;
        wb_addr  = AW'(wa);
        wb_data  = wd;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, '0);
    endtask

    function automatic int ra();
        if ($urandom_range(0, 9) == 0) return 31;
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        read_en = 1'b0; rs1 = '0; rs2 = '0; rd = '0; rd_we = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        model_reset();
        #3;
        check("rst.ready", 64'(bus_b1.operand_ready), 64'd0);
        check("rst.stall", 64'(bus_b1.stall),         64'd0);
        check("rst.busy",  64'(bus_b1.busy_vec),      64'd0);
        check("rst.r1",    64'(bus_b1.r1),            64'd0);
        check("rst.dbg",   64'(bus_b1.dbg_data),      64'd0);
        #9;
        rst = 1'b0;

        // Read after reset returns zeros with one-cycle latency.
        cyc(1'b1, 5, 6, 0, 1'b0, 1'b0, 0, '0);
        check("t1.ready", 64'(bus_b1.operand_ready), 64'd1);
        check("t1.r1",    64'(bus_b1.r1),            64'd0);
        check("t1.r2",    64'(bus_b1.r2),            64'd0);
        check("t1.dbg",   64'(bus_b1.dbg_data),      64'd0);

        // Written value is read back; x0 stays zero.
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 5, 32'h0000_00AA);
        cyc(1'b1, 5, 0, 0, 1'b0, 1'b0, 0, '0);
        check("t2.r1",   64'(bus_b0.r1),       64'h0000_00AA);
        check("t2.r2",   64'(bus_b0.r2),       64'd0);
        check("t2.busy", 64'(bus_b0.busy_vec), 64'd0);

        // RAW stall resolved by a writeback three cycles later.
        cyc(1'b1, 1, 2, 7, 1'b1, 1'b0, 0, '0);
        cyc(1'b1, 7, 0, 0, 1'b0, 1'b0, 0, '0);
        check("t3.stall", 64'(bus_b1.stall), 64'd1);
        idle();
        idle();
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 7, 32'h0000_1234);
        check("t3.b1.ready", 64'(bus_b1.operand_ready), 64'd1);
        check("t3.b1.r1",    64'(bus_b1.r1),            64'h0000_1234);
        check("t3.b0.ready", 64'(bus_b0.operand_ready), 64'd0);
        idle();
        check("t3.b0.ready2", 64'(bus_b0.operand_ready), 64'd1);
        check("t3.b0.r1",     64'(bus_b0.r1),            64'h0000_1234);

        // Issue to x9 in the same cycle its previous write retires: set wins.
        cyc(1'b1, 1, 2, 9, 1'b1, 1'b0, 0, '0);
        cyc(1'b1, 3, 4, 9, 1'b1, 1'b1, 9, 32'h0000_0099);
        check("t4.b1.busy9", 64'(bus_b1.busy_vec[9]),   64'd1);
        check("t4.b1.ready", 64'(bus_b1.operand_ready), 64'd1);
        check("t4.b0.stall", 64'(bus_b0.stall),         64'd1);
        idle();
        check("t4.b0.busy9", 64'(bus_b0.busy_vec[9]),   64'd1);

        // Stalled read of x9, dropped request, then completion with captured addresses.
        cyc(1'b1, 9, 0, 0, 1'b0, 1'b0, 0, '0);
        cyc(1'b1, 3, 3, 0, 1'b0, 1'b0, 0, '0);
        check("t5.drop",  64'(bus_b1.req_drop), 64'd1);
        check("t5.stall", 64'(bus_b1.stall),    64'd1);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 9, 32'h0000_0055);
        check("t5.b1.r1",   64'(bus_b1.r1),       64'h0000_0055);
        check("t5.b1.drop", 64'(bus_b1.req_drop), 64'd0);
        idle();
        check("t5.b0.r1", 64'(bus_b0.r1), 64'h0000_0055);
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 0, 32'hFFFF_FFFF);
        cyc(1'b1, 0, 0, 0, 1'b0, 1'b0, 0, '0);
        check("t5.x0", 64'(bus_b1.r1), 64'd0);

        // Debug tap, then asynchronous reset while waiting.
        cyc(1'b0, 0, 0, 0, 1'b0, 1'b1, 31, 32'hDEAD_BEEF);
        check("t6.dbg", 64'(bus_b1.dbg_data), 64'hDEAD_BEEF);
        cyc(1'b1, 1, 2, 12, 1'b1, 1'b0, 0, '0);
        cyc(1'b1, 12, 0, 0, 1'b0, 1'b0, 0, '0);
        check("t6.wait", 64'(bus_b1.stall), 64'd1);
        read_en = 1'b0; wb_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t6.rst.stall", 64'(bus_b1.stall),    64'd0);
        check("t6.rst.busy",  64'(bus_b1.busy_vec), 64'd0);
        check("t6.rst.b0",    64'(bus_b0.stall),    64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("t6.noready", 64'(bus_b1.operand_ready), 64'd0);
        idle();

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            cyc(($urandom_range(0, 1) == 1), ra(), ra(), ra(), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 1) == 1), ra(), XLEN'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
